// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter: FSM state
// encoding and default register-index / data widths.
package wb_arb_pkg;

  localparam int unsigned WbArbRegW  = 3;
  localparam int unsigned WbArbDataW = 16;

  // IDLE: queue empty. DRAIN: queue holds results, head waits for a free port.
  // FORCE: head starved too long, pipeline writeback is stalled.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StForce = 2'd2
  } wb_arb_state_e;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-result queue: DEPTH-entry {reg, data} FIFO with occupancy count,
// full/empty flags and a two-port register-compare lookup over valid entries.
module wb_pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned REG_W  = WbArbRegW,
  parameter int unsigned DATA_W = WbArbDataW
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [REG_W-1:0]           i_push_reg,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic                       i_pop,
  input  logic [REG_W-1:0]           i_chk_reg1,
  input  logic [REG_W-1:0]           i_chk_reg2,
  output logic [REG_W-1:0]           o_head_reg,
  output logic [DATA_W-1:0]          o_head_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [$clog2(DEPTH):0]     o_count_next,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_hit
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [REG_W-1:0]  r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW:0]     r_count;

  logic w_push;
  logic w_pop;

  assign o_full      = (r_count == (PtrW+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_push      = i_push & ~o_full;
  assign w_pop       = i_pop & ~o_empty;
  assign o_count     = r_count;
  assign o_head_reg  = r_reg[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    o_count_next = r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
  end

  // Pointers, count and per-entry valid bits; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      r_count <= o_count_next;
      if (w_pop) begin
        r_rd_ptr           <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr]  <= 1'b0;
      end
      // Placed after the pop so a push into the slot just freed keeps it valid.
      if (w_push) begin
        r_wr_ptr           <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr]  <= 1'b1;
      end
    end
  end

  // Entry payload storage; contents are only meaningful under r_valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_reg[r_wr_ptr]  <= i_push_reg;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  // Any valid entry targeting either lookup register; this cycle's push is not yet visible.
  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && ((r_reg[i] == i_chk_reg1) || (r_reg[i] == i_chk_reg2))) begin
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and a long-latency
// unit. Pipeline writes win; long-unit results queue and drain when the port is
// free; an aging counter forces a pipeline stall so the queue head is never starved.
// Optional feature: define WB_ARB_BYPASS_EN to let an idle long-unit result
// write the RF in the same cycle without being queued.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned REG_W    = WbArbRegW,
  parameter int unsigned DATA_W   = WbArbDataW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pipe_wr_en,
  input  logic [REG_W-1:0]  i_pipe_wr_reg,
  input  logic [DATA_W-1:0] i_pipe_wr_data,
  input  logic              i_lu_valid,
  input  logic [REG_W-1:0]  i_lu_reg,
  input  logic [DATA_W-1:0] i_lu_data,
  output logic              o_lu_ready,
  input  logic [REG_W-1:0]  i_chk_reg1,
  input  logic [REG_W-1:0]  i_chk_reg2,
  output logic              o_pend_hit,
  output logic              o_pipe_stall,
  output logic              o_rf_wr_en,
  output logic [REG_W-1:0]  o_rf_wr_reg,
  output logic [DATA_W-1:0] o_rf_wr_data
);

  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  wb_arb_state_e r_state;
  wb_arb_state_e w_state_next;
  logic [WaitW-1:0] r_wait_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_denied;
  logic              w_bypass;
  logic              w_full;
  logic              w_empty;
  logic [CntW-1:0]   w_count;
  logic [CntW-1:0]   w_count_next;
  logic [REG_W-1:0]  w_head_reg;
  logic [DATA_W-1:0] w_head_data;

`ifdef WB_ARB_BYPASS_EN
  assign w_bypass = (r_state == StIdle) & i_lu_valid & ~i_pipe_wr_en;
`else
  assign w_bypass = 1'b0;
`endif

  // No pop lookahead: a full queue refuses even if the head drains this cycle.
  assign o_lu_ready = ~w_full;
  assign w_push     = i_lu_valid & o_lu_ready & ~w_bypass;
  assign w_pop      = ~i_pipe_wr_en & ~w_empty;
  assign w_denied   = i_pipe_wr_en & ~w_empty;

  wb_pend_fifo #(
    .DEPTH  (DEPTH),
    .REG_W  (REG_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (w_push),
    .i_push_reg   (i_lu_reg),
    .i_push_data  (i_lu_data),
    .i_pop        (w_pop),
    .i_chk_reg1   (i_chk_reg1),
    .i_chk_reg2   (i_chk_reg2),
    .o_head_reg   (w_head_reg),
    .o_head_data  (w_head_data),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_hit        (o_pend_hit)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: leave IDLE on a push, escalate to FORCE once the head is starved.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_push) w_state_next = StDrain;
      end
      StDrain: begin
        if (w_pop && (w_count_next == '0)) begin
          w_state_next = StIdle;
        end else if (w_denied && (r_wait_cnt == WaitW'(MAX_WAIT - 1))) begin
          w_state_next = StForce;
        end
      end
      StForce: begin
        if (w_pop) w_state_next = (w_count_next == '0) ? StIdle : StDrain;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: stall the pipeline only while forcing the head out.
  always_comb begin
    o_pipe_stall = (r_state == StForce);
  end

  // Aging counter: counts denied head cycles in DRAIN, cleared on pop and in IDLE.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wait_cnt <= '0;
    end else if ((r_state == StIdle) || w_pop) begin
      r_wait_cnt <= '0;
    end else if (w_denied && (r_state == StDrain)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Write-port mux: pipeline first, then bypass, then queue head.
  always_comb begin
    o_rf_wr_en   = 1'b0;
    o_rf_wr_reg  = '0;
    o_rf_wr_data = '0;
    if (!i_rst) begin
      o_rf_wr_en = 1'b0;
    end else if (i_pipe_wr_en) begin
      o_rf_wr_en   = 1'b1;
      o_rf_wr_reg  = i_pipe_wr_reg;
      o_rf_wr_data = i_pipe_wr_data;
    end else if (w_bypass) begin
      o_rf_wr_en   = 1'b1;
      o_rf_wr_reg  = i_lu_reg;
      o_rf_wr_data = i_lu_data;
    end else if (!w_empty) begin
      o_rf_wr_en   = 1'b1;
      o_rf_wr_reg  = w_head_reg;
      o_rf_wr_data = w_head_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=4, MAX_WAIT=8).
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_wr_en;
  logic [2:0]  pipe_wr_reg;
  logic [15:0] pipe_wr_data;
  logic        lu_valid;
  logic [2:0]  lu_reg;
  logic [15:0] lu_data;
  logic        lu_ready;
  logic [2:0]  chk_reg1;
  logic [2:0]  chk_reg2;
  logic        pend_hit;
  logic        pipe_stall;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_reg;
  logic [15:0] rf_wr_data;

  int n_total = 0;
  int n_bad   = 0;

  wb_port_arbiter #(
    .DEPTH    (4),
    .MAX_WAIT (8),
    .REG_W    (3),
    .DATA_W   (16)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pipe_wr_en   (pipe_wr_en),
    .i_pipe_wr_reg  (pipe_wr_reg),
    .i_pipe_wr_data (pipe_wr_data),
    .i_lu_valid     (lu_valid),
    .i_lu_reg       (lu_reg),
    .i_lu_data      (lu_data),
    .o_lu_ready     (lu_ready),
    .i_chk_reg1     (chk_reg1),
    .i_chk_reg2     (chk_reg2),
    .o_pend_hit     (pend_hit),
    .o_pipe_stall   (pipe_stall),
    .o_rf_wr_en     (rf_wr_en),
    .o_rf_wr_reg    (rf_wr_reg),
    .o_rf_wr_data   (rf_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; inputs are then changed away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    settle();
  endtask

  task automatic check_rf(input string tag, input logic en, input logic [2:0] r,
                          input logic [15:0] d);
    check_eq({tag, "_en"}, 32'(rf_wr_en), 32'(en));
    if (en) begin
      check_eq({tag, "_reg"}, 32'(rf_wr_reg), 32'(r));
      check_eq({tag, "_data"}, 32'(rf_wr_data), 32'(d));
    end
  endtask

  logic [2:0]  t3_reg  [4];
  logic [15:0] t3_data [4];

  initial begin
    rst          = 1'b0;
    pipe_wr_en   = 1'b0;
    pipe_wr_reg  = '0;
    pipe_wr_data = '0;
    lu_valid     = 1'b0;
    lu_reg       = '0;
    lu_data      = '0;
    chk_reg1     = '0;
    chk_reg2     = '0;
    t3_reg  = '{3'd3, 3'd1, 3'd2, 3'd6};
    t3_data = '{16'h0100, 16'h0101, 16'h0102, 16'h0106};

    // Reset outputs, even with the pipeline requesting.
    settle();
    pipe_wr_en = 1'b1;
    settle();
    check_eq("rst_ready", 32'(lu_ready), 32'd1);
    check_eq("rst_hit", 32'(pend_hit), 32'd0);
    check_eq("rst_stall", 32'(pipe_stall), 32'd0);
    check_eq("rst_wr_en", 32'(rf_wr_en), 32'd0);
    pipe_wr_en = 1'b0;
    do_reset();

    // Single long-unit result on an idle port.
    lu_valid = 1'b1; lu_reg = 3'd3; lu_data = 16'h1234;
    settle();
    check_eq("t1_ready", 32'(lu_ready), 32'd1);
`ifdef WB_ARB_BYPASS_EN
    check_rf("t2_bypass", 1'b1, 3'd3, 16'h1234);
    tick();
    lu_valid = 1'b0;
    settle();
    check_rf("t2_after", 1'b0, 3'd0, 16'h0);
`else
    check_rf("t1_same", 1'b0, 3'd0, 16'h0);
    tick();
    lu_valid = 1'b0;
    settle();
    check_rf("t1_next", 1'b1, 3'd3, 16'h1234);
    tick();
    check_rf("t1_empty", 1'b0, 3'd0, 16'h0);
`endif
    check_eq("t1_hit", 32'(pend_hit), 32'd0);

    // Pipeline holds the port while four results queue up.
    do_reset();
    pipe_wr_en = 1'b1; pipe_wr_reg = 3'd5; pipe_wr_data = 16'hAAAA;
    for (int i = 0; i < 4; i++) begin
      lu_valid = 1'b1; lu_reg = t3_reg[i]; lu_data = t3_data[i];
      settle();
      check_eq($sformatf("t3_ready%0d", i), 32'(lu_ready), 32'd1);
      check_rf($sformatf("t3_pipe%0d", i), 1'b1, 3'd5, 16'hAAAA);
      tick();
    end
    lu_valid = 1'b0;
    chk_reg1 = 3'd3; chk_reg2 = 3'd7;
    settle();
    check_eq("t3_full", 32'(lu_ready), 32'd0);
    check_eq("t3_hit3", 32'(pend_hit), 32'd1);
    chk_reg1 = 3'd7; chk_reg2 = 3'd0;
    settle();
    check_eq("t3_miss", 32'(pend_hit), 32'd0);
    chk_reg2 = 3'd6;
    settle();
    check_eq("t3_hit6", 32'(pend_hit), 32'd1);

    // Drain from full: a refused push, then a push alongside a pop, FIFO order kept.
    pipe_wr_en = 1'b0;
    lu_valid = 1'b1; lu_reg = 3'd7; lu_data = 16'h0707;
    chk_reg1 = 3'd7; chk_reg2 = 3'd7;
    settle();
    check_eq("t5_refuse", 32'(lu_ready), 32'd0);
    check_rf("t5_pop0", 1'b1, 3'd3, 16'h0100);
    tick();
    check_eq("t5_ready", 32'(lu_ready), 32'd1);
    check_eq("t5_nohit7", 32'(pend_hit), 32'd0);
    check_rf("t5_pop1", 1'b1, 3'd1, 16'h0101);
    tick();
    lu_valid = 1'b0;
    settle();
    check_eq("t5_hit7", 32'(pend_hit), 32'd1);
    check_eq("t5_cnt3", 32'(lu_ready), 32'd1);
    check_rf("t5_pop2", 1'b1, 3'd2, 16'h0102);
    tick();
    check_rf("t5_pop3", 1'b1, 3'd6, 16'h0106);
    tick();
    check_rf("t5_pop4", 1'b1, 3'd7, 16'h0707);
    tick();
    check_rf("t5_done", 1'b0, 3'd0, 16'h0);
    check_eq("t5_nohit", 32'(pend_hit), 32'd0);

    // Aging: stall after exactly 8 denied cycles; pipeline still wins in FORCE.
    do_reset();
    pipe_wr_en = 1'b1; pipe_wr_reg = 3'd2; pipe_wr_data = 16'hBEEF;
    lu_valid = 1'b1; lu_reg = 3'd4; lu_data = 16'h4444;
    settle();
    tick();
    lu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      check_eq($sformatf("t4_nostall%0d", i), 32'(pipe_stall), 32'd0);
      tick();
    end
    check_eq("t4_stall", 32'(pipe_stall), 32'd1);
    check_rf("t4_pipe_wins", 1'b1, 3'd2, 16'hBEEF);
    tick();
    check_eq("t4_stall_hold", 32'(pipe_stall), 32'd1);
    pipe_wr_en = 1'b0;
    settle();
    check_rf("t4_head", 1'b1, 3'd4, 16'h4444);
    tick();
    check_eq("t4_release", 32'(pipe_stall), 32'd0);
    check_rf("t4_empty", 1'b0, 3'd0, 16'h0);

    // Reset with three entries queued discards them immediately.
    do_reset();
    pipe_wr_en = 1'b1; pipe_wr_reg = 3'd0; pipe_wr_data = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      lu_valid = 1'b1; lu_reg = t3_reg[i]; lu_data = t3_data[i];
      settle();
      tick();
    end
    lu_valid = 1'b0;
    chk_reg1 = 3'd3; chk_reg2 = 3'd2;
    settle();
    check_eq("t6_prehit", 32'(pend_hit), 32'd1);
    pipe_wr_en = 1'b0;
    rst = 1'b0;
    settle();
    check_eq("t6_hit", 32'(pend_hit), 32'd0);
    check_eq("t6_wr_en", 32'(rf_wr_en), 32'd0);
    check_eq("t6_ready", 32'(lu_ready), 32'd1);
    check_eq("t6_stall", 32'(pipe_stall), 32'd0);
    tick();
    rst = 1'b1;
    settle();
    check_rf("t6_after", 1'b0, 3'd0, 16'h0);
    check_eq("t6_after_hit", 32'(pend_hit), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
